// File: rtl/pc_pkg.sv
// pc_pkg: shared widths and FSM state encoding for the fetch unit.
package pc_pkg;
  localparam int PC_W = 12;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control inputs and fetch status outputs of the program counter unit.
interface pc_fetch_if #(
  parameter int PC_W = pc_pkg::PC_W,
  parameter int CNT_W = pc_pkg::CNT_W
) ();
  logic start;
  logic [PC_W-1:0] start_addr;
  logic stall;
  logic halt;
  logic branch_en;
  logic taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic fetch_en;
  logic done;
  logic bad_target;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output start, start_addr, stall, halt, branch_en, taken, target,
    input pc, fetch_en, done, bad_target, cycle_count
  );
  modport slave (
    input start, start_addr, stall, halt, branch_en, taken, target,
    output pc, fetch_en, done, bad_target, cycle_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at its all-ones maximum.
module sat_counter #(
  parameter int W = pc_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clear ? '0 : (enable && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter with start/stall/halt/branch control and a RUN-cycle counter.
module pc_fetch #(
  parameter int PC_W = pc_pkg::PC_W,
  parameter int CNT_W = pc_pkg::CNT_W
) (
  input logic clk,
  input logic rst_n,
  pc_fetch_if.slave bus
);
  import pc_pkg::*;
  state_t state;
  logic [PC_W-1:0] pc;
  logic [CNT_W-1:0] cnt;
  logic bad_target;
  logic run;
  logic go;
  always_comb begin
    run = state == RUN;
    go = !run && bus.start;
  end
  assign bus.pc = pc;
  assign bus.fetch_en = run;
  assign bus.done = state == DONE;
  assign bus.bad_target = bad_target;
  assign bus.cycle_count = cnt;
  // stall outranks halt, so a halt seen under stall waits for the stall to clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      bad_target <= 1'b0;
    end else if (go) begin
      state <= RUN;
      pc <= bus.start_addr;
      bad_target <= 1'b0;
    end else if (run && !bus.stall) begin
      if (bus.halt) state <= DONE;
      else if (bus.branch_en && bus.taken) begin
        pc <= bus.target;
        if (bus.target == '0) bad_target <= 1'b1;
      end else pc <= pc + 1'b1;
    end
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .clear(go),
    .enable(run),
    .count(cnt)
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scoreboard bench for pc_fetch plus a narrow sat_counter saturation check.
module tb_pc_fetch;
  typedef struct {
    logic [11:0] pc;
    logic fe;
    logic dn;
    logic bad;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sc_clr = 1'b0;
  logic sc_en = 1'b0;
  logic [2:0] sc_q;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  int m_st;
  logic [11:0] m_pc;
  logic [15:0] m_cnt;
  logic m_bad;
  int m_sc;
  pc_fetch_if #(.PC_W(12), .CNT_W(16)) bus ();
  pc_fetch #(.PC_W(12), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  sat_counter #(.W(3)) u_sc (.clk(clk), .rst_n(rst_n), .clear(sc_clr), .enable(sc_en), .count(sc_q));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    m_st = 0;
    m_pc = '0;
    m_cnt = '0;
    m_bad = 1'b0;
  endtask
  function automatic exp_t mexp();
    exp_t e;
    e.pc = m_pc;
    e.fe = m_st == 1;
    e.dn = m_st == 2;
    e.bad = m_bad;
    e.cnt = m_cnt;
    return e;
  endfunction
  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(e.pc));
    chk({tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(e.fe));
    chk({tag, ".done"}, 32'(bus.done), 32'(e.dn));
    chk({tag, ".bad"}, 32'(bus.bad_target), 32'(e.bad));
    chk({tag, ".cnt"}, 32'(bus.cycle_count), 32'(e.cnt));
  endtask
  task automatic step(input logic s, input logic [11:0] sa, input logic sl, input logic h,
                      input logic be, input logic tk, input logic [11:0] tg, input string tag);
    exp_t e;
    bus.start = s;
    bus.start_addr = sa;
    bus.stall = sl;
    bus.halt = h;
    bus.branch_en = be;
    bus.taken = tk;
    bus.target = tg;
    if (m_st != 1) begin
      if (s) begin
        m_st = 1;
        m_pc = sa;
        m_cnt = '0;
        m_bad = 1'b0;
      end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (sl) ;
      else if (h) m_st = 2;
      else if (be && tk) begin
        m_pc = tg;
        if (tg == 12'd0) m_bad = 1'b1;
      end else m_pc = m_pc + 12'd1;
    end
    q.push_back(mexp());
    @(posedge clk);
    #1;
    e = q.pop_front();
    cmp(tag, e);
  endtask
  task automatic idle(input string tag);
    step(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, tag);
  endtask
  task automatic br(input logic [11:0] tg, input string tag);
    step(1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1, tg, tag);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.stall = 1'b0;
    bus.halt = 1'b0;
    bus.branch_en = 1'b0;
    bus.taken = 1'b0;
    bus.target = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", mexp());
    rst_n = 1'b1;
    step(1'b1, 12'd10, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "start10");
    for (int i = 0; i < 5; i++) idle($sformatf("seq%0d", i));
    step(1'b1, 12'd99, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "run_ignores_start");
    br(12'd20, "br20");
    br(12'd323, "br323");
    br(12'd20, "br20b");
    step(1'b0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd323, "not_taken");
    br(12'd40, "br40");
    step(1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, "stall_halt0");
    step(1'b0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, "stall_halt1");
    step(1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, "halt");
    for (int i = 0; i < 3; i++) step(1'b0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, $sformatf("done_hold%0d", i));
    step(1'b1, 12'd4095, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "start4095");
    idle("wrap");
    step(1'b0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0, "stalled_br0");
    br(12'd0, "br0");
    idle("bad_sticky0");
    br(12'd55, "bad_sticky1");
    step(1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, "halt2");
    step(1'b1, 12'd5, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "restart5");
    br(12'd100, "br100");
    #2 rst_n = 1'b0;
    #1 mreset();
    cmp("async_rst", mexp());
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle("idle_wait0");
    step(1'b0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'd9, "idle_wait1");
    step(1'b1, 12'd7, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "start7");
    step(1'b0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, "halt3");
    step(1'b1, 12'd201, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, "start201");
    idle("after201");
    m_sc = 0;
    sc_clr = 1'b1;
    @(posedge clk);
    #1 chk("sc_clear", 32'(sc_q), 32'(m_sc));
    sc_clr = 1'b0;
    sc_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (m_sc < 7) m_sc++;
      #1 chk($sformatf("sc_up%0d", i), 32'(sc_q), 32'(m_sc));
    end
    sc_en = 1'b0;
    @(posedge clk);
    #1 chk("sc_hold", 32'(sc_q), 32'(m_sc));
    sc_clr = 1'b1;
    sc_en = 1'b1;
    m_sc = 0;
    @(posedge clk);
    #1 chk("sc_clr_prio", 32'(sc_q), 32'(m_sc));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: PC_W, 12, width of program counter and branch target.
REQ-002 Parameter: CNT_W, 16, width of the executed-cycle counter.
REQ-003 Ports: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins a program run at start_addr.
REQ-007 start_addr  input  PC_W  first instruction address, sampled only when start is accepted.
REQ-008 stall  input  1  hold the current PC this cycle.
REQ-009 halt  input  1  the current instruction is a halt.
REQ-010 branch_en  input  1  the current instruction is a branch.
REQ-011 taken  input  1  the branch condition is true; ignored unless branch_en=1.
REQ-012 target  input  PC_W  absolute branch destination from the label lookup table.
REQ-013 pc  output  PC_W  current instruction address.
REQ-014 fetch_en  output  1  instruction memory read enable; high only in RUN.
REQ-015 done  output  1  level; high in DONE state.
REQ-016 bad_target  output  1  sticky; a taken branch resolved to target 0, the lookup table's unmapped-label default.
REQ-017 cycle_count  output  CNT_W  RUN cycles since the last accepted start.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE; fetch_en=(state==RUN) and done=(state==DONE), both combinational from state.
REQ-019 IDLE: start=1 -> state RUN, pc<=start_addr, cycle_count<=0, bad_target<=0; otherwise hold all registers.
REQ-020 DONE: behave as IDLE (start restarts the run); done deasserts the cycle after start is accepted.
REQ-021 RUN: start SHALL be ignored.
REQ-022 RUN next-PC priority: stall (hold pc) > halt (state<=DONE, hold pc) > branch_en&&taken (pc<=target) > default (pc<=pc+1).
REQ-023 Increment SHALL wrap modulo 2^PC_W: pc 4095 -> 0 with no flag.
REQ-024 branch_en=1, taken=0 -> pc<=pc+1.
REQ-025 Latency: a redirect takes effect on pc in the cycle after the edge that samples branch_en&&taken; there are no bubbles and no delay slots.
REQ-026 halt during stall SHALL be ignored until stall=0.
REQ-027 Taken, unstalled branch with target==0 -> bad_target<=1, and the branch is still taken; bad_target remains set until the next accepted start or reset.
REQ-028 cycle_count SHALL increment on every RUN cycle, including stalled and halting cycles, and saturate at 2^CNT_W-1; it is frozen in IDLE/DONE.
REQ-029 Inputs other than start/start_addr SHALL have no effect outside RUN.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=0, cycle_count=0, bad_target=0, hence fetch_en=0 and done=0.
REQ-031 Reset asserted mid-run SHALL abandon the run; after release the block waits in IDLE for start.
REQ-032 start coincident with the first edge after rst_n release SHALL be accepted.

Structure
REQ-033 Shared package pc_pkg SHALL hold PC_W, CNT_W defaults and the state enum (IDLE=0, RUN=1, DONE=2, 2-bit).
REQ-034 The saturating counter SHALL be a sub-module sat_counter (clear, enable, count).
REQ-035 The FSM and PC register SHALL remain in pc_fetch.

Verification
REQ-036 Reset then start, start_addr=10, no control 5 cycles -> pc 10,11,12,13,14; fetch_en=1; cycle_count=5.
REQ-037 In RUN at pc=20, branch_en=1, taken=1, target=323 -> pc=323 next cycle; same with taken=0 -> pc=21.
REQ-038 stall=1 2 cycles with halt=1 at pc=40 -> pc holds 40, state RUN; stall=0 -> DONE, done=1, pc=40, cycle_count frozen.
REQ-039 start_addr=4095, run 2 cycles -> pc 4095, 0; branch taken with target=0 -> bad_target=1 until next start.
REQ-040 rst_n low mid-run at pc=100 -> pc=0, fetch_en=0 asynchronously; start in DONE with start_addr=201 -> RUN, pc=201, cycle_count=0.
